// File: rtl/program_memory_arbiter.sv
// Arbitrates the single ProgramMemory read port between instruction fetch and a debug reader,
// with debug anti-starvation, address translation/checking and registered responses.
module program_memory_arbiter #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 256,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = 32'h0040_0000,
  parameter int                    STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  FetchReq,
  input  logic [DATA_WIDTH-1:0] FetchAddress,
  output logic                  FetchGrant,
  output logic                  FetchValid,
  output logic [DATA_WIDTH-1:0] FetchData,
  output logic                  FetchErr,
  input  logic                  DbgReq,
  input  logic [DATA_WIDTH-1:0] DbgAddress,
  output logic                  DbgGrant,
  output logic                  DbgValid,
  output logic [DATA_WIDTH-1:0] DbgData,
  output logic                  DbgErr,
  output logic [DATA_WIDTH-1:0] MemAddress,
  input  logic [DATA_WIDTH-1:0] MemInstruction
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);
  localparam logic [DATA_WIDTH-3:0] DEPTH_LIM = (DATA_WIDTH-2)'(MEMORY_DEPTH);

  // Index 0 is the fetch requester, index 1 the debug requester.
  logic [DATA_WIDTH-1:0] req_addr   [2];
  logic [DATA_WIDTH-1:0] req_offset [2];
  logic [1:0]            req_err;

  logic [CW-1:0] starve_reg, starve_next;
  logic          force_dbg;
  logic          fetch_grant, dbg_grant;

  assign req_addr[0] = FetchAddress;
  assign req_addr[1] = DbgAddress;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_check
      assign req_offset[gi] = req_addr[gi] - BASE_ADDRESS;
      assign req_err[gi]    = (req_addr[gi][1:0] != 2'b00)
                           || (req_addr[gi] < BASE_ADDRESS)
                           || (req_offset[gi][DATA_WIDTH-1:2] >= DEPTH_LIM);
    end
  endgenerate

  assign force_dbg = (starve_reg == STARVE_MAX);

  always_comb begin
    fetch_grant = 1'b0;
    dbg_grant   = 1'b0;
    if (!reset) begin
      if (force_dbg && DbgReq) begin
        dbg_grant = 1'b1;
      end else if (FetchReq) begin
        fetch_grant = 1'b1;
      end else if (DbgReq) begin
        dbg_grant = 1'b1;
      end
    end
  end

  assign FetchGrant = fetch_grant;
  assign DbgGrant   = dbg_grant;

  always_comb begin
    MemAddress = '0;
    if (fetch_grant) begin
      MemAddress = req_offset[0];
    end else if (dbg_grant) begin
      MemAddress = req_offset[1];
    end
  end

  // Counts consecutive debug denials; any debug grant or idle debug clears it.
  always_comb begin
    starve_next = '0;
    if (DbgReq && !dbg_grant) begin
      starve_next = force_dbg ? starve_reg : starve_reg + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_reg <= '0;
      FetchValid <= 1'b0;
      FetchData  <= '0;
      FetchErr   <= 1'b0;
      DbgValid   <= 1'b0;
      DbgData    <= '0;
      DbgErr     <= 1'b0;
    end else begin
      starve_reg <= starve_next;
      FetchValid <= fetch_grant;
      DbgValid   <= dbg_grant;
      if (fetch_grant) begin
        FetchData <= req_err[0] ? '0 : MemInstruction;
        FetchErr  <= req_err[0];
      end
      if (dbg_grant) begin
        DbgData <= req_err[1] ? '0 : MemInstruction;
        DbgErr  <= req_err[1];
      end
    end
  end

endmodule

// File: tb/tb_program_memory_arbiter.sv
// Directed bench for program_memory_arbiter: per-cycle grant/address checks plus a
// scoreboard of expected registered responses compared one cycle later.
module tb_program_memory_arbiter;

  localparam logic [31:0] BASE = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        FetchReq, DbgReq;
  logic [31:0] FetchAddress, DbgAddress;
  logic        FetchGrant, FetchValid, FetchErr;
  logic        DbgGrant, DbgValid, DbgErr;
  logic [31:0] FetchData, DbgData, MemAddress, MemInstruction;

  logic [31:0] rom [256];

  typedef struct {
    logic        fv;
    logic        dv;
    logic [31:0] fd;
    logic        fe;
    logic [31:0] dd;
    logic        de;
  } resp_t;

  resp_t sb[$];

  int total = 0;
  int bad   = 0;
  int step  = 0;

  // Reference view of the held response registers.
  logic [31:0] m_fd = '0, m_dd = '0;
  logic        m_fe = 1'b0, m_de = 1'b0;

  program_memory_arbiter dut (
    .clk(clk), .reset(reset),
    .FetchReq(FetchReq), .FetchAddress(FetchAddress), .FetchGrant(FetchGrant),
    .FetchValid(FetchValid), .FetchData(FetchData), .FetchErr(FetchErr),
    .DbgReq(DbgReq), .DbgAddress(DbgAddress), .DbgGrant(DbgGrant),
    .DbgValid(DbgValid), .DbgData(DbgData), .DbgErr(DbgErr),
    .MemAddress(MemAddress), .MemInstruction(MemInstruction)
  );

  always #5 clk = ~clk;

  always_comb begin
    MemInstruction = 32'hDEAD_BEEF;
    if (MemAddress < 32'd1024) MemInstruction = rom[MemAddress[9:2]];
  end

  function automatic logic exp_err(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a[1:0] != 2'b00) || (a < BASE) || ((off >> 2) >= 32'd256);
  endfunction

  function automatic logic [31:0] exp_data(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (exp_err(a)) return 32'h0;
    return rom[off[9:2]];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL step=%0d %s observed=%h expected=%h", step, tag, obs, exp);
    end
  endtask

  task automatic check_resp();
    resp_t r;
    r = sb.pop_front();
    chk("fetch_valid", FetchValid, r.fv);
    chk("dbg_valid", DbgValid, r.dv);
    chk("fetch_data", FetchData, r.fd);
    chk("fetch_err", FetchErr, r.fe);
    chk("dbg_data", DbgData, r.dd);
    chk("dbg_err", DbgErr, r.de);
  endtask

  // g: expected owner this cycle, 0 none, 1 fetch, 2 debug.
  task automatic cycle(input logic fr, input logic [31:0] fa,
                       input logic dr, input logic [31:0] da, input int g);
    resp_t r;
    logic [31:0] exp_mem;
    step++;
    @(negedge clk);
    FetchReq = fr; FetchAddress = fa; DbgReq = dr; DbgAddress = da;
    #1;
    exp_mem = (g == 1) ? fa - BASE : (g == 2) ? da - BASE : 32'h0;
    chk("fetch_grant", {31'b0, FetchGrant}, {31'b0, g == 1});
    chk("dbg_grant", {31'b0, DbgGrant}, {31'b0, g == 2});
    chk("mem_address", MemAddress, exp_mem);
    if (g == 1) begin m_fd = exp_data(fa); m_fe = exp_err(fa); end
    if (g == 2) begin m_dd = exp_data(da); m_de = exp_err(da); end
    r.fv = (g == 1); r.dv = (g == 2);
    r.fd = m_fd; r.fe = m_fe; r.dd = m_dd; r.de = m_de;
    sb.push_back(r);
    @(posedge clk);
    #1;
    check_resp();
    $display("step %0d fr=%0b fa=%h dr=%0b da=%h grant=%0d fv=%0b fd=%h fe=%0b dv=%0b dd=%h de=%0b",
             step, fr, fa, dr, da, g, FetchValid, FetchData, FetchErr, DbgValid, DbgData, DbgErr);
  endtask

  // Reset held for one cycle while both requesters are asking.
  task automatic reset_cycle();
    resp_t r;
    step++;
    @(negedge clk);
    reset = 1'b1; FetchReq = 1'b1; FetchAddress = BASE; DbgReq = 1'b1; DbgAddress = BASE + 32'h10;
    #1;
    chk("rst_fetch_grant", {31'b0, FetchGrant}, 32'h0);
    chk("rst_dbg_grant", {31'b0, DbgGrant}, 32'h0);
    chk("rst_mem_address", MemAddress, 32'h0);
    m_fd = '0; m_fe = 1'b0; m_dd = '0; m_de = 1'b0;
    r.fv = 1'b0; r.dv = 1'b0; r.fd = '0; r.fe = 1'b0; r.dd = '0; r.de = 1'b0;
    sb.push_back(r);
    @(posedge clk);
    #1;
    check_resp();
    $display("step %0d reset cycle fv=%0b dv=%0b fd=%h dd=%h", step, FetchValid, DbgValid, FetchData, DbgData);
    @(negedge clk);
    reset = 1'b0; FetchReq = 1'b0; DbgReq = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = {8'hC0, 8'(i), 16'(i * 37 + 5)};
    reset = 1'b1; FetchReq = 1'b0; DbgReq = 1'b0; FetchAddress = '0; DbgAddress = '0;
    repeat (2) @(posedge clk);
    reset_cycle();

    // Sequential fetches from the start of .text.
    cycle(1, BASE + 32'h0, 0, 0, 1);
    cycle(1, BASE + 32'h4, 0, 0, 1);
    cycle(1, BASE + 32'h8, 0, 0, 1);

    // Contention: fetch wins four times, debug forced on the fifth, then fetch again.
    for (int k = 0; k < 4; k++) cycle(1, BASE + 32'(16 + 4 * k), 1, BASE + 32'h100, 1);
    cycle(1, BASE + 32'h20, 1, BASE + 32'h100, 2);
    cycle(1, BASE + 32'h20, 0, 0, 1);
    // Starve counter restarted: another full four denials before debug wins.
    for (int k = 0; k < 4; k++) cycle(1, BASE + 32'(36 + 4 * k), 1, BASE + 32'h104, 1);
    cycle(1, BASE + 32'h34, 1, BASE + 32'h104, 2);

    // Misaligned debug read; then a clean debug read alone.
    cycle(0, 0, 1, BASE + 32'h2, 2);
    cycle(0, 0, 1, BASE + 32'h3F8, 2);

    // Range boundaries on fetch.
    cycle(1, 32'h003F_FFFC, 0, 0, 1);
    cycle(1, BASE + 32'h3FC, 0, 0, 1);
    cycle(1, BASE + 32'h400, 0, 0, 1);

    // Idle: held data/err must persist.
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(1, BASE + 32'h40, 1, BASE + 32'h44, 1);
    cycle(0, 0, 1, BASE + 32'h44, 2);
    cycle(0, 0, 0, 0, 0);

    // Reset with a pending request, and reset clearing a partially built starve count.
    cycle(1, BASE + 32'h50, 1, BASE + 32'h60, 1);
    cycle(1, BASE + 32'h54, 1, BASE + 32'h60, 1);
    reset_cycle();
    for (int k = 0; k < 4; k++) cycle(1, BASE + 32'(88 + 4 * k), 1, BASE + 32'h60, 1);
    cycle(1, BASE + 32'h68, 1, BASE + 32'h60, 2);
    cycle(0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
